nabp_shifter: RTL and testbench

- Drives the mapper side of the shifter/mapper protocol: issues sh_kick, paces sh_shift_en, and ends each projection line with sh_done.
- Reads the projection-line RAM at the mapper-supplied address fr_s_val and shifts the returned samples into the processing-element chain.
- Sits between state control, which starts one line per angle, and the PE array. The mapper and RAM are its peers.

---
 rtl/nabp_shifter_pkg.sv | 26 ++
 rtl/nabp_shifter_pipe.sv | 48 ++++
 rtl/nabp_shifter.sv | 126 ++++++++++++
 tb/tb_nabp_shifter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_shifter_pkg.sv
// -----------------------------------------------------------------------------
// nabp_shifter_pkg
// Shared definitions for the projection-line shifter: default geometry of the
// projection line, the derived shift counter width and the shifter state type.
// -----------------------------------------------------------------------------
package nabp_shifter_pkg;

  // Address width of the projection-line RAM (bin width of the line size)
  localparam int kSLength    = 9;
  // Width of one projection sample
  localparam int kDataLength = 12;
  // Shift steps per line, equal to the PE chain length (must be >= 2)
  localparam int kShiftCount = 256;
  // Width of the per-line shift counter
  localparam int kCountW     = $clog2(kShiftCount);

  typedef enum logic [2:0] {
    ready_s = 3'd0,
    kick_s  = 3'd1,
    wait_s  = 3'd2,
    shift_s = 3'd3,
    drain_s = 3'd4,
    done_s  = 3'd5
  } shifter_state_e;

endpackage

// File: rtl/nabp_shifter_pipe.sv
// -----------------------------------------------------------------------------
// nabp_shifter_pipe
// Aligns RAM read data with the shift it belongs to. The valid flag follows the
// shift enable by one cycle, which matches the one-cycle RAM read latency, so
// the sample arriving on data_p1 is presented to the PE chain in the same cycle
// as its pe_shift pulse. Between pulses pe_data holds the last shifted sample.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   vld_p0   in   a RAM read for the chain was issued this cycle
//   data_p1  in   RAM read data (belongs to the read issued one cycle earlier)
//   pe_shift out  PE chain shifts pe_data in this cycle
//   pe_data  out  sample into the head of the PE chain
// -----------------------------------------------------------------------------
module nabp_shifter_pipe
  import nabp_shifter_pkg::*;
#(
  parameter int DATA_W = kDataLength
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] data_p1,
  output logic              pe_shift,
  output logic [DATA_W-1:0] pe_data
);

  logic              vld_p1;
  logic [DATA_W-1:0] hold_p1;

  // ---- stage p0 -> p1: read issued -> read data valid ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      hold_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p1) begin
        hold_p1 <= data_p1;
      end
    end
  end

  assign pe_shift = vld_p1;
  assign pe_data  = vld_p1 ? data_p1 : hold_p1;

endmodule

// File: rtl/nabp_shifter.sv
// -----------------------------------------------------------------------------
// nabp_shifter
// Mapper-side driver of the shifter/mapper handshake for one projection line.
// Kicks the mapper, waits for its acknowledge, then paces the mapper with
// sh_shift_en while reading the projection-line RAM at the mapper's address
// and shifting the returned samples into the PE chain. The line ends with a
// one-cycle sh_done to the mapper and a one-cycle ss_done to state control.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   ss_start     in   start one line (single-cycle pulse, honoured only idle)
//   ss_busy      out  high from acceptance of ss_start until ss_done
//   ss_done      out  one-cycle pulse after the last sample was shifted
//   sh_kick      out  mapper: begin mapping (held until sh_ack)
//   sh_ack       in   mapper is in its mapping state
//   sh_shift_en  out  mapper: advance accumulator this cycle
//   sh_done      out  mapper: line finished, return to ready
//   fr_s_val     in   mapper address (combinational from mapper state)
//   fr_addr      out  RAM read address
//   fr_data      in   RAM read data, one-cycle latency
//   pe_stall     in   PE chain cannot accept a shift this cycle
//   pe_data      out  sample into head of PE chain
//   pe_shift     out  PE chain shifts pe_data in this cycle
// -----------------------------------------------------------------------------
module nabp_shifter
  import nabp_shifter_pkg::*;
#(
  parameter int ADDR_W = kSLength,
  parameter int DATA_W = kDataLength,
  parameter int STAGES = kShiftCount
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ss_start,
  output logic              ss_busy,
  output logic              ss_done,
  output logic              sh_kick,
  input  logic              sh_ack,
  output logic              sh_shift_en,
  output logic              sh_done,
  input  logic [ADDR_W-1:0] fr_s_val,
  output logic [ADDR_W-1:0] fr_addr,
  input  logic [DATA_W-1:0] fr_data,
  input  logic              pe_stall,
  output logic [DATA_W-1:0] pe_data,
  output logic              pe_shift
);

  localparam int               CNT_W    = $clog2(STAGES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STAGES - 1);

  shifter_state_e   state;
  logic [CNT_W-1:0] count;
  logic             shift_en;

  // A stall blocks the step entirely: the mapper accumulator is not advanced,
  // so fr_s_val, and with it fr_addr, stays put until the chain is ready.
  assign shift_en = (state == shift_s) && !pe_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ready_s;
      count <= '0;
    end else begin
      unique case (state)
        ready_s: begin
          if (ss_start) begin
            state <= kick_s;
            count <= '0;
          end
        end
        kick_s: begin
          state <= wait_s;
        end
        wait_s: begin
          if (sh_ack) begin
            state <= shift_s;
          end
        end
        shift_s: begin
          if (shift_en) begin
            // The last step leaves the counter at STAGES-1 instead of wrapping.
            if (count == LAST_CNT) begin
              state <= drain_s;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        drain_s: begin
          state <= done_s;
        end
        done_s: begin
          state <= ready_s;
        end
        default: begin
          state <= ready_s;
        end
      endcase
    end
  end

  // Outputs are decoded from the state register only (plus the stall gate),
  // so an asynchronous reset drops all of them immediately.
  assign ss_busy     = (state != ready_s);
  assign ss_done     = (state == done_s);
  assign sh_kick     = (state == kick_s) || (state == wait_s);
  assign sh_shift_en = shift_en;
  // drain_s covers the RAM latency of the final read; the mapper sees sh_done
  // only after its last accumulator update.
  assign sh_done     = (state == drain_s);
  assign fr_addr     = ((state == shift_s) || (state == drain_s)) ? fr_s_val : '0;

  nabp_shifter_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .vld_p0   (shift_en),
    .data_p1  (fr_data),
    .pe_shift (pe_shift),
    .pe_data  (pe_data)
  );

endmodule

// File: tb/tb_nabp_shifter.sv
// -----------------------------------------------------------------------------
// tb_nabp_shifter
// Bench for nabp_shifter with an 8-stage chain. Stimulus pushes, per line, the
// expected event timing and the expected sample sequence into queues; a
// separate monitor process watches the DUT on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_nabp_shifter;

  typedef struct {
    int kf;   // first sh_kick cycle
    int kl;   // last sh_kick cycle
    int ef;   // first sh_shift_en cycle
    int el;   // last sh_shift_en cycle
    int ec;   // number of sh_shift_en cycles
    int shd;  // sh_done cycle
    int ssd;  // ss_done cycle
    int pf;   // first pe_shift cycle
    int pl;   // last pe_shift cycle
    int pc;   // number of pe_shift pulses
    int bc;   // number of ss_busy cycles
  } line_t;

  logic        clk;
  logic        reset_n;
  logic        ss_start;
  logic        ss_busy;
  logic        ss_done;
  logic        sh_kick;
  logic        sh_ack;
  logic        sh_shift_en;
  logic        sh_done;
  logic [8:0]  fr_s_val;
  logic [8:0]  fr_addr;
  logic [11:0] fr_data;
  logic        pe_stall;
  logic [11:0] pe_data;
  logic        pe_shift;

  logic [8:0]  accu;
  logic [8:0]  mapper_base;
  logic        finish_req;

  line_t       line_q[$];
  logic [11:0] exp_q[$];

  int checks;
  int errors;

  nabp_shifter #(
    .ADDR_W (9),
    .DATA_W (12),
    .STAGES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ss_start    (ss_start),
    .ss_busy     (ss_busy),
    .ss_done     (ss_done),
    .sh_kick     (sh_kick),
    .sh_ack      (sh_ack),
    .sh_shift_en (sh_shift_en),
    .sh_done     (sh_done),
    .fr_s_val    (fr_s_val),
    .fr_addr     (fr_addr),
    .fr_data     (fr_data),
    .pe_stall    (pe_stall),
    .pe_data     (pe_data),
    .pe_shift    (pe_shift)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM contents: a fixed, address-dependent pattern
  function automatic logic [11:0] ram_f(input logic [8:0] a);
    logic [11:0] r;
    r = {3'b000, a} * 12'd37 + 12'd5;
    return r;
  endfunction

  // Mapper and RAM model: accumulator loads on kick, steps by 3 per shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accu    <= '0;
      fr_data <= '0;
    end else begin
      if (sh_kick) begin
        accu <= mapper_base;
      end else if (sh_shift_en) begin
        accu <= accu + 9'd3;
      end
      fr_data <= ram_f(fr_addr);
    end
  end
  assign fr_s_val = accu;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    int    cyc_n;
    int    rel;
    bit    in_line;
    bit    acked;
    bit    prev_stall;
    logic [8:0] prev_addr;
    line_t a;
    line_t e;
    cyc_n = 0; rel = 0; in_line = 0; acked = 0; prev_stall = 0; prev_addr = '0;
    checks = 0; errors = 0;
    a = '{-1, -1, -1, -1, 0, -1, -1, -1, -1, 0, 0};
    forever begin
      @(negedge clk);
      cyc_n++;
      if (cyc_n > 20000) begin
        errors++;
        $display("FAIL watchdog: got %0d cycles expected at most 20000", cyc_n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!reset_n) begin
        chk("rst_ctrl_outs", int'({ss_busy, ss_done, sh_kick, sh_shift_en, sh_done, pe_shift}), 0);
        chk("rst_pe_data", int'(pe_data), 0);
        chk("rst_fr_addr", int'(fr_addr), 0);
        in_line = 0;
        acked   = 0;
        exp_q.delete();
      end else if (in_line) begin
        rel++;
        if (sh_kick)     begin if (a.kf < 0) a.kf = rel; a.kl = rel; end
        if (sh_shift_en) begin if (a.ef < 0) a.ef = rel; a.el = rel; a.ec++; end
        if (pe_shift)    begin if (a.pf < 0) a.pf = rel; a.pl = rel; a.pc++; end
        if (sh_done) a.shd = rel;
        if (ss_busy) a.bc++;
        if (pe_shift) begin
          if (exp_q.size() == 0) chk("pe_shift_unexpected", 1, 0);
          else                   chk("pe_data", int'(pe_data), int'(exp_q.pop_front()));
        end
        if (!acked) begin
          chk("wait_kick", int'(sh_kick), 1);
          chk("wait_no_shift_en", int'(sh_shift_en), 0);
          chk("wait_fr_addr", int'(fr_addr), 0);
        end else if (!ss_done) begin
          chk("fr_addr_map", int'(fr_addr), int'(fr_s_val));
          if (sh_done)       chk("done_no_shift_en", int'(sh_shift_en), 0);
          else if (pe_stall) chk("stall_no_shift_en", int'(sh_shift_en), 0);
          if (prev_stall)    chk("stall_addr_hold", int'(fr_addr), int'(prev_addr));
        end
        prev_stall = acked && !ss_done && !sh_done && !sh_shift_en;
        prev_addr  = fr_addr;
        if (sh_kick && sh_ack) acked = 1;
        if (ss_done) begin
          a.ssd = rel;
          if (line_q.size() == 0) begin
            chk("ss_done_unexpected", 1, 0);
          end else begin
            e = line_q.pop_front();
            chk("kick_first", a.kf, e.kf);
            chk("kick_last", a.kl, e.kl);
            chk("shift_en_first", a.ef, e.ef);
            chk("shift_en_last", a.el, e.el);
            chk("shift_en_count", a.ec, e.ec);
            chk("sh_done_cycle", a.shd, e.shd);
            chk("ss_done_cycle", a.ssd, e.ssd);
            chk("pe_shift_first", a.pf, e.pf);
            chk("pe_shift_last", a.pl, e.pl);
            chk("pe_shift_count", a.pc, e.pc);
            chk("busy_cycles", a.bc, e.bc);
          end
          in_line = 0;
        end else if (rel > 300) begin
          chk("line_timeout", rel, 300);
          in_line = 0;
        end
      end else begin
        chk("idle_ctrl_outs", int'({ss_busy, ss_done, sh_kick, sh_shift_en, sh_done, pe_shift}), 0);
        chk("idle_fr_addr", int'(fr_addr), 0);
        if (ss_start) begin
          in_line    = 1;
          rel        = 0;
          acked      = 0;
          prev_stall = 0;
          a = '{-1, -1, -1, -1, 0, -1, -1, -1, -1, 0, 0};
        end
      end
      if (finish_req) begin
        chk("lines_left", line_q.size(), 0);
        chk("samples_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_samples(input logic [8:0] base);
    logic [8:0] ad;
    ad = base;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(ram_f(ad));
      ad = ad + 9'd3;
    end
  endtask

  // Runs one line; cycle numbers are relative to the ss_start cycle (0).
  task automatic run_line(input int ack_at, input int st_lo, input int st_hi,
                          input int extra_start, input logic [8:0] base,
                          input line_t exp);
    mapper_base = base;
    push_samples(base);
    line_q.push_back(exp);
    ss_start = 1'b1;
    for (int r = 1; r < 200; r++) begin
      tick();
      ss_start = (r == extra_start);
      sh_ack   = (r == ack_at);
      pe_stall = (r >= st_lo) && (r <= st_hi);
      if (ss_done) break;
    end
    ss_start = 1'b0;
    sh_ack   = 1'b0;
    pe_stall = 1'b0;
  endtask

  localparam line_t L_PLAIN = '{1, 3, 4, 11, 8, 12, 13, 5, 12, 8, 13};
  localparam line_t L_STALL = '{1, 3, 4, 13, 8, 14, 15, 5, 14, 8, 15};
  localparam line_t L_LATE  = '{1, 23, 24, 31, 8, 32, 33, 25, 32, 8, 33};

  initial begin
    reset_n     = 1'b0;
    ss_start    = 1'b0;
    sh_ack      = 1'b0;
    pe_stall    = 1'b0;
    mapper_base = '0;
    finish_req  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // Plain line, ack at cycle 3
    run_line(3, -1, -1, -1, 9'd10, L_PLAIN);
    tick();
    // Chain stalled on cycles 6-7
    run_line(3, 6, 7, -1, 9'd40, L_STALL);
    tick();
    // Acknowledge delayed by 20 cycles
    run_line(23, -1, -1, -1, 9'd100, L_LATE);
    tick();
    // Extra ss_start during shift_s is ignored
    run_line(3, -1, -1, 7, 9'd200, L_PLAIN);
    tick();

    // Reset in shift_s while count is 4 (cycle 8): abandoned line
    mapper_base = 9'd300;
    push_samples(9'd300);
    ss_start = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      tick();
      ss_start = 1'b0;
      sh_ack   = (r == 3);
    end
    reset_n = 1'b0;
    sh_ack  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();

    // Full line after the reset
    run_line(3, -1, -1, -1, 9'd450, L_PLAIN);
    tick();
    // Back-to-back lines; stall during drain_s has no effect
    run_line(3, 12, 12, -1, 9'd500, L_PLAIN);
    tick();
    run_line(3, -1, -1, -1, 9'd7, L_PLAIN);

    repeat (3) tick();
    finish_req = 1'b1;
    repeat (10) tick();
    $display("FAIL monitor_end: got no summary expected summary");
    $fatal(1, "monitor did not terminate");
  end

endmodule
